// File: rtl/uart_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | uart_pkg : frame constants and bit-period helper for uart_tx/rx |
// | Revision : 1.0                                                  |
// +-----------------------------------------------------------------+
package uart_pkg;

   localparam int unsigned DATA_BITS    = 8;
   localparam logic        START_BIT    = 1'b0;
   localparam logic        STOP_BIT     = 1'b1;
   localparam int unsigned ASCII_OFFSET = 48;

   // Clocks per bit, rounded to nearest.
   function automatic int unsigned cpb_calc(input int unsigned f, input int unsigned baud);
      return (f + baud / 2) / baud;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_bitcnt.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | uart_rx_bitcnt : baud counter, sync clear, terminal-count flag  |
// | Revision : 1.0                                                  |
// +-----------------------------------------------------------------+
module uart_rx_bitcnt #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic [W-1:0] terminal,
   output logic         done
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = clr ? '0 : cnt_q + W'(1);
      done  = (cnt_q == terminal);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | uart_rx : 8N1 receiver, mid-bit sampling, offset removal        |
// | Revision : 1.0                                                  |
// +-----------------------------------------------------------------+
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned BAUD   = 115200,
   parameter int unsigned F      = 50000000,
   parameter int unsigned OFFSET = ASCII_OFFSET
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int unsigned CPB  = cpb_calc(F, BAUD);
   localparam int unsigned HALF = CPB / 2;
   localparam int unsigned CW   = $clog2(CPB);
   localparam int unsigned IW   = $clog2(DATA_BITS);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic          sync1_q, rx_s_q, rx_prev_q;
   logic [IW-1:0] idx_q, idx_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    data_q, data_d;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;
   logic          cnt_clr, cnt_done, fall;
   logic [CW-1:0] terminal;

   // Flops reset low so a line stuck low through reset never looks like an edge.
   assign fall     = ~rx_s_q & rx_prev_q;
   assign terminal = (state_q == ST_START) ? CW'(HALF - 1) : CW'(CPB - 1);

   uart_rx_bitcnt #(.W(CW)) u_bitcnt (
      .clk      (clk),
      .rst      (rst),
      .clr      (cnt_clr),
      .terminal (terminal),
      .done     (cnt_done)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      cnt_clr = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_clr = 1'b1;
            if (fall) begin
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (cnt_done) begin
               cnt_clr = 1'b1;
               idx_d   = '0;
               state_d = (rx_s_q == START_BIT) ? ST_DATA : ST_IDLE;
            end
         end
         ST_DATA: begin
            if (cnt_done) begin
               cnt_clr        = 1'b1;
               shift_d[idx_q] = rx_s_q;
               idx_d          = idx_q + IW'(1);
               if (idx_q == IW'(DATA_BITS - 1)) begin
                  state_d = ST_STOP;
               end
            end
         end
         ST_STOP: begin
            if (cnt_done) begin
               cnt_clr = 1'b1;
               state_d = ST_IDLE;
               if (rx_s_q == STOP_BIT) begin
                  data_d  = shift_q - 8'(OFFSET);
                  valid_d = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q   <= 1'b0;
         rx_s_q    <= 1'b0;
         rx_prev_q <= 1'b0;
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         sync1_q   <= rx;
         rx_s_q    <= sync1_q;
         rx_prev_q <= rx_s_q;
         state_q   <= state_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
      end
   end

   assign data      = data_q;
   assign valid     = valid_q;
   assign frame_err = ferr_q;
   assign busy      = (state_q != ST_IDLE) | fall;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_uart_rx : bench for uart_rx (offset and raw instances)       |
// | Revision : 1.0                                                  |
// +-----------------------------------------------------------------+
module tb_uart_rx;

   localparam int BAUD = 1000000;
   localparam int FREQ = 10000000;
   localparam int CPB  = 10;
   localparam int OFF  = 48;
   // Pin falls at cycle n; rx_s sees it at n+2 (t0); pulse at t0+HALF+9*CPB+1.
   localparam int LAT  = 2 + 5 + 9 * CPB + 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b0;
   logic [7:0] data, rdata;
   logic       valid, frame_err, busy;
   logic       rvalid, rframe_err, rbusy;

   uart_rx #(.BAUD(BAUD), .F(FREQ), .OFFSET(OFF)) dut (
      .clk(clk), .rst(rst), .rx(rx),
      .data(data), .valid(valid), .frame_err(frame_err), .busy(busy)
   );

   uart_rx #(.BAUD(BAUD), .F(FREQ), .OFFSET(0)) dut_raw (
      .clk(clk), .rst(rst), .rx(rx),
      .data(rdata), .valid(rvalid), .frame_err(rframe_err), .busy(rbusy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         c;
      logic       v, fe, rv, rfe;
      logic [7:0] d, rd;
   } ev_t;

   ev_t  evq[$];
   int   busy_rise = -1, busy_fall = -1, rise_cnt = 0;
   logic busy_prev = 1'b0;
   int   total = 0, bad = 0;
   logic [7:0] mdl_d = 8'h00, mdl_rd = 8'h00;

   always @(posedge clk) begin
      #1;
      if (valid | frame_err | rvalid | rframe_err) begin
         ev_t e;
         e.c = cyc; e.v = valid; e.fe = frame_err; e.rv = rvalid; e.rfe = rframe_err;
         e.d = data; e.rd = rdata;
         evq.push_back(e);
      end
      if (busy && !busy_prev) begin
         busy_rise = cyc;
         rise_cnt++;
      end
      if (!busy && busy_prev) busy_fall = cyc;
      busy_prev = busy;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] sub_off(input logic [7:0] b);
      return 8'((int'(b) + 256 - OFF) % 256);
   endfunction

   task automatic send(input logic [7:0] b, input logic stop_ok, output int n);
      n  = cyc;
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop_ok;
      repeat (CPB) @(negedge clk);
   endtask

   // Reference: one pulse LAT cycles after the start fall; data updates only on good stop.
   task automatic expect_frame(input string nm, input int n, input logic stop_ok, input logic [7:0] b);
      ev_t e;
      if (stop_ok) begin
         mdl_d  = sub_off(b);
         mdl_rd = b;
      end
      chk({nm, "_present"}, 32'(evq.size() != 0), 32'd1);
      if (evq.size() != 0) begin
         e = evq.pop_front();
         chk({nm, "_cycle"}, e.c, n + LAT);
         chk({nm, "_valid"}, e.v, stop_ok);
         chk({nm, "_ferr"}, e.fe, !stop_ok);
         chk({nm, "_rvalid"}, e.rv, stop_ok);
         chk({nm, "_rferr"}, e.rfe, !stop_ok);
         chk({nm, "_data"}, e.d, mdl_d);
         chk({nm, "_rdata"}, e.rd, mdl_rd);
      end
   endtask

   task automatic expect_quiet(input string nm);
      chk({nm, "_nopulse"}, evq.size(), 0);
      evq.delete();
   endtask

   typedef struct {
      logic [7:0] b;
      logic [7:0] exp_d;
      logic [7:0] exp_raw;
   } vec_t;

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[6];
      int   n, n2, gap;
      logic ok, prev_ok;
      logic [7:0] b;

      vecs[0] = '{8'h35, 8'h05, 8'h35};
      vecs[1] = '{8'h30, 8'h00, 8'h30};
      vecs[2] = '{8'h39, 8'h09, 8'h39};
      vecs[3] = '{8'h2F, 8'hFF, 8'h2F};
      vecs[4] = '{8'h00, 8'hD0, 8'h00};
      vecs[5] = '{8'hFF, 8'hCF, 8'hFF};

      // Reset values, line held low through and after reset.
      repeat (5) @(negedge clk);
      chk("rst_data", data, 8'h00);
      chk("rst_valid", valid, 1'b0);
      chk("rst_ferr", frame_err, 1'b0);
      chk("rst_busy", busy, 1'b0);
      rst = 1'b0;
      repeat (50) @(negedge clk);
      expect_quiet("held_low");
      chk("held_low_busy", rise_cnt, 0);
      rx = 1'b1;
      repeat (10) @(negedge clk);
      send(8'h38, 1'b1, n);
      expect_frame("held_low_frame", n, 1'b1, 8'h38);
      chk("held_low_lit", data, 8'h08);

      // Table vectors.
      for (int i = 0; i < 6; i++) begin
         repeat (5) @(negedge clk);
         send(vecs[i].b, 1'b1, n);
         expect_frame($sformatf("vec%0d", i), n, 1'b1, vecs[i].b);
         chk($sformatf("vec%0d_lit", i), data, vecs[i].exp_d);
         chk($sformatf("vec%0d_rlit", i), rdata, vecs[i].exp_raw);
         if (i == 0) begin
            chk("single_busy_rise", busy_rise, n + 2);
            chk("single_busy_fall", busy_fall, n + LAT);
         end
      end
      expect_quiet("vec_extra");

      // Raw back-to-back, no idle gap.
      repeat (5) @(negedge clk);
      send(8'h00, 1'b1, n);
      send(8'hFF, 1'b1, n2);
      expect_frame("b2b_first", n, 1'b1, 8'h00);
      expect_frame("b2b_second", n2, 1'b1, 8'hFF);
      chk("b2b_rlit", rdata, 8'hFF);

      // Glitch: 3 cycles low.
      repeat (5) @(negedge clk);
      n  = cyc;
      rx = 1'b0;
      repeat (3) @(negedge clk);
      rx = 1'b1;
      repeat (20) @(negedge clk);
      expect_quiet("glitch");
      chk("glitch_busy_rise", busy_rise, n + 2);
      chk("glitch_busy_fall", busy_fall, n + 8);
      chk("glitch_data", data, mdl_d);

      // Framing error followed by a break.
      repeat (5) @(negedge clk);
      send(8'h41, 1'b0, n);
      repeat (200) @(negedge clk);
      rx = 1'b1;
      repeat (10) @(negedge clk);
      expect_frame("ferr", n, 1'b0, 8'h41);
      expect_quiet("ferr_break");
      send(8'h31, 1'b1, n);
      expect_frame("after_ferr", n, 1'b1, 8'h31);
      chk("after_ferr_lit", data, 8'h01);

      // Reset during data bit 3 of 0x37.
      repeat (5) @(negedge clk);
      b  = 8'h37;
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx = b[i];
         repeat ((i == 3) ? 4 : CPB) @(negedge clk);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_data", data, 8'h00);
      chk("midrst_valid", valid, 1'b0);
      chk("midrst_ferr", frame_err, 1'b0);
      chk("midrst_busy", busy, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      rx  = 1'b1;
      mdl_d  = 8'h00;
      mdl_rd = 8'h00;
      repeat (30) @(negedge clk);
      expect_quiet("midrst");
      send(8'h32, 1'b1, n);
      expect_frame("after_rst", n, 1'b1, 8'h32);
      chk("after_rst_lit", data, 8'h02);

      // Randomized frames, random gaps, occasional bad stop bit.
      prev_ok = 1'b1;
      for (int i = 0; i < 30; i++) begin
         b   = 8'($urandom_range(0, 255));
         ok  = ($urandom_range(0, 4) != 0);
         gap = $urandom_range(0, 12);
         if (!prev_ok && gap == 0) gap = 1;
         if (gap > 0) begin
            rx = 1'b1;
            repeat (gap) @(negedge clk);
         end
         send(b, ok, n);
         expect_frame($sformatf("rnd%0d", i), n, ok, b);
         prev_ok = ok;
      end
      rx = 1'b1;
      repeat (20) @(negedge clk);
      expect_quiet("rnd_end");
      chk("final_data", data, mdl_d);
      chk("final_rdata", rdata, mdl_rd);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

Serial receiver paired with the `uart_tx` stage. It takes the asynchronous serial line and synchronises it to `clk`. It detects a start bit, samples 8 data bits LSB-first at mid-bit, and checks the stop bit. It then presents the byte, with the ASCII offset removed, as a one-cycle valid pulse. It sits between the board RX pin and the application logic that consumes received characters.

## Interface
- `BAUD`, 115200: line bit rate.
- `F`, 50000000: `clk` frequency in Hz.
- `OFFSET`, 48: subtracted modulo 256 from the received byte; this undoes the transmitter's ASCII '0' shift. Set to 0 for raw bytes.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial line; idle high.
- `data`  out  8  last good byte minus `OFFSET`; holds its value between frames.
- `valid`  out  1  one-cycle pulse; `data` is new in this same cycle.
- `frame_err`  out  1  one-cycle pulse; the stop bit was sampled low.
- `busy`  out  1  high from start-edge detection until the end-of-frame pulse cycle (exclusive).

## Operation
- Derived constants:
  - CPB = (F+BAUD/2)/BAUD, which is 434 at the defaults.
  - HALF = CPB/2 (integer), which is 217.
  - Counter width is $clog2(CPB).
- Input path:
  - Two-flop synchroniser gives `rx_s`; one further flop gives `rx_prev`.
  - All three flops reset to 0. The receiver therefore arms only after the line has been seen high, and a line held low through reset never starts a frame.
- FSM states: IDLE, START, DATA, STOP.
  - **IDLE:** on `rx_s`=0 and `rx_prev`=1, go to START and clear the bit counter. All other inputs are ignored.
  - **START:** at count HALF-1, sample `rx_s`.
    - If 0, go to DATA with bit index 0 and counter cleared.
    - If 1, it was a glitch: go to IDLE with no pulse.
  - **DATA:** at count CPB-1, shift `rx_s` into bit[index] (LSB first) and clear the counter.
    - After index 7 is sampled, go to STOP.
  - **STOP:** at count CPB-1, sample `rx_s` and go to IDLE.
    - If 1, register `data` = shift_reg − OFFSET (8-bit wrap) and pulse `valid` the next cycle.
    - If 0, pulse `frame_err` the next cycle and leave `data` unchanged.
- Re-arming after a framing error needs a fresh high-to-low edge. A break condition (line held low) therefore produces exactly one `frame_err`.
- `valid` and `frame_err` are never high together.

## Timing
- Reset values: `data`=0x00, `valid`=0, `frame_err`=0, `busy`=0, FSM in IDLE, counters 0.
- Pin-to-`rx_s` latency is 2 cycles.
- Let t0 be the cycle in which IDLE sees the edge. Then:
  - start-bit sample at t0+HALF;
  - data bit k sampled at t0+HALF+(k+1)·CPB, for k = 0..7;
  - stop-bit sample at t0+HALF+9·CPB;
  - `valid` or `frame_err` high at t0+HALF+9·CPB+1 for exactly one cycle;
  - `busy` falls in that same cycle.
- Back-to-back frames: the next start edge can be detected in the pulse cycle or any later cycle, with no dead time beyond that.
- Reset asserted mid-frame:
  - next cycle is IDLE and all outputs take their reset values;
  - the partial byte is discarded and no pulse is produced;
  - the receiver re-arms only after `rx_s` is seen high.
- Baud error tolerance: ±4% total between transmitter and receiver.

## Structure
- Shared package `uart_pkg`, common with `uart_tx`:
  - CPB formula as a function of F and BAUD;
  - frame constants START_BIT=0, STOP_BIT=1, DATA_BITS=8;
  - ASCII offset default 48.
- FSM state encoding stays local to `uart_rx`.
- One natural sub-module, `uart_rx_bitcnt`: a baud counter with synchronous clear and a terminal-count compare input. It is used for both the HALF and CPB waits.

## Test plan
All scenarios use BAUD=1000000 and F=10000000, so CPB=10 and HALF=5.

- **Single frame:** send 0x35 ('5') at 10 clk/bit → `valid` pulses once at t0+96, `data`=0x05, `frame_err`=0, `busy` high for cycles t0..t0+95.
- **Raw mode:** OFFSET=0, send 0x00 then 0xFF back-to-back with no idle gap → two `valid` pulses 100 cycles apart, `data`=0x00 then 0xFF.
- **Glitch:** `rx` low for 3 cycles, then high → no `valid` or `frame_err`, `busy` drops by t0+6, and `data` is unchanged.
- **Framing error:** send 0x41 with the stop bit forced low, then hold the line low for 200 cycles → exactly one `frame_err` at t0+96, no `valid`, `data` keeps its prior value. After the line returns high, a clean 0x31 yields `data`=0x01.
- **Reset mid-frame:** assert `rst` for 1 cycle during data bit 3 of 0x37 → next cycle all outputs are reset, no pulse for that frame. The following clean 0x32 yields `data`=0x02.
- **Held-low at reset release:** `rx`=0 through and after reset for 50 cycles, then high, then a clean 0x38 → no pulse before that frame, then `data`=0x08.
